// File: rtl/fft_mem_pkg.sv
// Shared types and sizes for the FFT working-memory arbiter and its memory command bus.
package fft_mem_pkg;

   localparam int FFT_MEM_ADDR_W = 8;
   localparam int FFT_MEM_DATA_W = 32;

   typedef logic port_id_t;

   typedef struct packed {
      logic                      en;
      logic                      we;
      logic [FFT_MEM_ADDR_W-1:0] addr;
      logic [FFT_MEM_DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/fft_mem_arbiter_if.sv
// Request/response handshakes of both requesters plus the memory macro command and read-data bus.
interface fft_mem_arbiter_if #(
   parameter int ADDR_WIDTH = fft_mem_pkg::FFT_MEM_ADDR_W,
   parameter int DATA_WIDTH = fft_mem_pkg::FFT_MEM_DATA_W
);
   logic [1:0]              req_valid_i;
   logic [1:0]              req_ready_o;
   logic [1:0]              req_we_i;
   logic [2*ADDR_WIDTH-1:0] req_addr_i;
   logic [2*DATA_WIDTH-1:0] req_wdata_i;
   logic [1:0]              rsp_valid_o;
   logic [DATA_WIDTH-1:0]   rsp_rdata_o;
   logic                    mem_en_o;
   logic                    mem_we_o;
   logic [ADDR_WIDTH-1:0]   mem_addr_o;
   logic [DATA_WIDTH-1:0]   mem_wdata_o;
   logic [DATA_WIDTH-1:0]   mem_rdata_i;

   // Arbiter side.
   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   // Requester/memory side.
   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/fft_mem_rr_grant.sv
// Combinational two-port round-robin grant with a bounded burst for the current owner.
module fft_mem_rr_grant
   import fft_mem_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic [1:0] i_valid,
   input  port_id_t   i_owner,
   input  logic [3:0] i_burst_cnt,
   output logic [1:0] o_grant
);

   logic w_owner_keeps;

   // A zero count only exists straight after reset: the owner has no burst running yet,
   // so the non-owner (port 0) takes the first contended slot.
   assign w_owner_keeps = (i_burst_cnt != 4'd0) && (i_burst_cnt < 4'(MAX_BURST));

   always_comb begin
      o_grant = 2'b00;
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11: begin
            if (w_owner_keeps) o_grant = i_owner ? 2'b10 : 2'b01;
            else               o_grant = i_owner ? 2'b01 : 2'b10;
         end
         default: o_grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/fft_mem_arbiter.sv
// Shares one single-port 256x32 memory between the butterfly engine (port 0) and the host path
// (port 1): round-robin accept, registered memory command, in-order read return two cycles later.
module fft_mem_arbiter
   import fft_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = FFT_MEM_ADDR_W,
   parameter int DATA_WIDTH = FFT_MEM_DATA_W,
   parameter int MAX_BURST  = 4
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   fft_mem_arbiter_if.slave    bus
);

   logic [1:0]            w_grant;
   logic                  w_accept;
   port_id_t              w_gid;
   logic                  w_acc_we;
   logic [ADDR_WIDTH-1:0] w_acc_addr;
   logic [DATA_WIDTH-1:0] w_acc_wdata;

   port_id_t              r_owner;
   logic [3:0]            r_burst_cnt;
   mem_cmd_t              r_cmd;
   logic                  r_vld_p1;
   port_id_t              r_id_p1;
   logic                  r_vld_p2;
   port_id_t              r_id_p2;

   fft_mem_rr_grant #(.MAX_BURST(MAX_BURST)) u_grant (
      .i_valid     (bus.req_valid_i),
      .i_owner     (r_owner),
      .i_burst_cnt (r_burst_cnt),
      .o_grant     (w_grant)
   );

   // Ready is forced low while reset is held so nothing is accepted into a clearing pipe.
   assign bus.req_ready_o = reset_n_i ? w_grant : 2'b00;
   assign w_accept        = |(bus.req_valid_i & bus.req_ready_o);
   assign w_gid           = w_grant[1];
   assign w_acc_we        = w_gid ? bus.req_we_i[1] : bus.req_we_i[0];
   assign w_acc_addr      = w_gid ? bus.req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : bus.req_addr_i[ADDR_WIDTH-1:0];
   assign w_acc_wdata     = w_gid ? bus.req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : bus.req_wdata_i[DATA_WIDTH-1:0];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_owner     <= 1'b1;
         r_burst_cnt <= 4'd0;
      end else if (w_accept) begin
         if (w_gid == r_owner) begin
            if (r_burst_cnt < 4'(MAX_BURST)) r_burst_cnt <= r_burst_cnt + 4'd1;
         end else begin
            r_owner     <= w_gid;
            r_burst_cnt <= 4'd1;
         end
      end
   end

   // ---- stage p1: registered memory command and read tag ----
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cmd    <= '0;
         r_vld_p1 <= 1'b0;
         r_id_p1  <= 1'b0;
      end else begin
         r_cmd.en <= w_accept;
         r_cmd.we <= w_accept & w_acc_we;
         if (w_accept) begin
            r_cmd.addr  <= w_acc_addr;
            r_cmd.wdata <= w_acc_wdata;
         end
         r_vld_p1 <= w_accept & ~w_acc_we;
         r_id_p1  <= w_gid;
      end
   end

   // ---- stage p2: tag lines up with memory read data ----
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_vld_p2 <= 1'b0;
         r_id_p2  <= 1'b0;
      end else begin
         r_vld_p2 <= r_vld_p1;
         r_id_p2  <= r_id_p1;
      end
   end

   assign bus.mem_en_o    = r_cmd.en;
   assign bus.mem_we_o    = r_cmd.we;
   assign bus.mem_addr_o  = r_cmd.addr;
   assign bus.mem_wdata_o = r_cmd.wdata;
   assign bus.rsp_valid_o = {r_vld_p2 & r_id_p2, r_vld_p2 & ~r_id_p2};
   assign bus.rsp_rdata_o = r_vld_p2 ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_fft_mem_arbiter.sv
// Bench for fft_mem_arbiter: behavioural memory, request-level reference model, directed table
// and hand sequences, then randomized traffic.
module tb_fft_mem_arbiter;

   localparam int MAX_BURST = 4;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   fft_mem_arbiter_if bus ();

   fft_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_BURST(MAX_BURST)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus)
   );

   // Synchronous single-port memory macro, never cleared by reset.
   logic [31:0] mem [256] = '{default: 32'h0};
   logic [31:0] mem_rdata = 32'h0;
   assign bus.mem_rdata_i = mem_rdata;
   always @(posedge clk) begin
      if (bus.mem_en_o) begin
         if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
         else              mem_rdata <= mem[bus.mem_addr_o];
      end
   end

   // Reference model: expected memory contents in acceptance order, queue of due responses,
   // and the current run of consecutive accepts.
   typedef struct { int due; int port; logic [31:0] data; } rsp_t;
   rsp_t        rq[$];
   logic [31:0] ref_mem [256] = '{default: 32'h0};
   int          run_port, run_len, cyc;
   logic        exp_en, exp_we;
   logic [7:0]  exp_addr;
   logic [31:0] exp_wdata;

   logic [1:0]  obs_rdy, obs_rsp;
   logic [31:0] obs_data;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [1:0] v, we;
      logic [7:0] a0, a1;
      logic [31:0] d0, d1;
      logic [1:0] e_rdy, e_rsp;
      logic [31:0] e_data;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      rq.delete();
      run_port  = 1;
      run_len   = 0;
      exp_en    = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = 8'h0;
      exp_wdata = 32'h0;
   endtask

   function automatic int model_grant();
      logic [1:0] vv;
      vv = bus.req_valid_i;
      if (!reset_n || vv == 2'b00) return -1;
      if (vv == 2'b01) return 0;
      if (vv == 2'b10) return 1;
      if (run_len > 0 && run_len < MAX_BURST) return run_port;
      return 1 - run_port;
   endfunction

   task automatic set_port(input int p, input logic vl, input logic w,
                           input logic [7:0] ad, input logic [31:0] dt);
      bus.req_valid_i[p] = vl;
      bus.req_we_i[p]    = w;
      if (p == 0) begin
         bus.req_addr_i[7:0]   = ad;
         bus.req_wdata_i[31:0] = dt;
      end else begin
         bus.req_addr_i[15:8]   = ad;
         bus.req_wdata_i[63:32] = dt;
      end
   endtask

   // One clock: compare everything at the falling edge, advance the model, return after the rise.
   task automatic step();
      int          g;
      logic [1:0]  e_rdy, e_rsp;
      logic [31:0] e_data;
      logic [7:0]  ad;
      @(negedge clk);
      g        = model_grant();
      e_rdy    = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
      e_rsp    = 2'b00;
      e_data   = 32'h0;
      obs_rdy  = bus.req_ready_o;
      obs_rsp  = bus.rsp_valid_o;
      obs_data = bus.rsp_rdata_o;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         e_rsp  = (rq[0].port == 1) ? 2'b10 : 2'b01;
         e_data = rq[0].data;
         void'(rq.pop_front());
      end
      chk("ready", 64'(obs_rdy), 64'(e_rdy));
      chk("rsp_valid", 64'(obs_rsp), 64'(e_rsp));
      chk("rsp_rdata", 64'(obs_data), 64'(e_data));
      chk("mem_en", 64'(bus.mem_en_o), 64'(exp_en));
      chk("mem_we", 64'(bus.mem_we_o), 64'(exp_we));
      chk("mem_addr", 64'(bus.mem_addr_o), 64'(exp_addr));
      chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(exp_wdata));
      exp_en = 1'b0;
      exp_we = 1'b0;
      if (g >= 0) begin
         ad        = (g == 1) ? bus.req_addr_i[15:8] : bus.req_addr_i[7:0];
         exp_en    = 1'b1;
         exp_we    = bus.req_we_i[g];
         exp_addr  = ad;
         exp_wdata = (g == 1) ? bus.req_wdata_i[63:32] : bus.req_wdata_i[31:0];
         if (exp_we) ref_mem[ad] = exp_wdata;
         else        rq.push_back('{due: cyc + 2, port: g, data: ref_mem[ad]});
         if (g == run_port) begin
            if (run_len < MAX_BURST) run_len++;
         end else begin
            run_port = g;
            run_len  = 1;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int waited;
      cyc = 0;
      tbl[0] = '{2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0,        2'b01, 2'b00, 32'h0};
      tbl[1] = '{2'b01, 2'b00, 8'h10, 8'h00, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0};
      tbl[2] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0};
      tbl[3] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b01, 32'hDEADBEEF};
      tbl[4] = '{2'b10, 2'b10, 8'h00, 8'hFF, 32'h0,        32'h12345678, 2'b10, 2'b00, 32'h0};
      tbl[5] = '{2'b01, 2'b00, 8'hFF, 8'h00, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0};
      tbl[6] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0};
      tbl[7] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b01, 32'h12345678};

      // Reset held with both ports requesting.
      reset_n = 1'b0;
      model_reset();
      set_port(0, 1'b1, 1'b0, 8'h00, 32'h0);
      set_port(1, 1'b1, 1'b0, 8'h01, 32'h0);
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ready", 64'(obs_rdy), 64'h0);
         chk("rst_rsp", 64'(obs_rsp), 64'h0);
         chk("rst_mem_en", 64'(bus.mem_en_o), 64'h0);
      end
      reset_n = 1'b1;
      step();
      chk("first_contended_ready", 64'(obs_rdy), 64'h1);
      set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
      step();
      step();

      // Directed table: single read, then cross-port read-after-write.
      for (int i = 0; i < 8; i++) begin
         set_port(0, tbl[i].v[0], tbl[i].we[0], tbl[i].a0, tbl[i].d0);
         set_port(1, tbl[i].v[1], tbl[i].we[1], tbl[i].a1, tbl[i].d1);
         step();
         chk($sformatf("tbl%0d_ready", i), 64'(obs_rdy), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_rsp", i), 64'(obs_rsp), 64'(tbl[i].e_rsp));
         chk($sformatf("tbl%0d_rdata", i), 64'(obs_data), 64'(tbl[i].e_data));
      end

      // Contention from a fresh reset: bursts of MAX_BURST alternate, starting with port 0.
      reset_n = 1'b0;
      model_reset();
      step();
      reset_n = 1'b1;
      set_port(0, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
      set_port(1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
      for (int k = 0; k < 16; k++) begin
         step();
         chk($sformatf("contend_grant%0d", k), 64'(obs_rdy), ((k / MAX_BURST) % 2 == 1) ? 64'h2 : 64'h1);
         if (obs_rdy[0]) set_port(0, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
         if (obs_rdy[1]) set_port(1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
      end

      // Lone requester on port 1 is never throttled; port 0 then gets in within MAX_BURST cycles.
      set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      for (int k = 0; k < 10; k++) begin
         set_port(1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
         step();
         chk($sformatf("lone_ready%0d", k), 64'(obs_rdy), 64'h2);
      end
      set_port(0, 1'b1, 1'b0, 8'h20, 32'h0);
      waited = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         waited++;
         if (obs_rdy[0]) break;
         if (obs_rdy[1]) set_port(1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
      end
      chk("p0_wait_within_burst", 64'(waited <= MAX_BURST), 64'h1);
      set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
      step();
      step();

      // Randomized traffic on a small address window to stress read-after-write and ordering.
      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!bus.req_valid_i[p] || obs_rdy[p])
               set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                        8'($urandom_range(0, 15)), $urandom);
            else if ($urandom_range(0, 9) == 0)
               bus.req_valid_i[p] = 1'b0;
         end
         step();
      end
      set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
      step();
      step();

      // Reset one cycle after a read accept drops the response but keeps memory contents.
      set_port(0, 1'b1, 1'b1, 8'h33, 32'hA5A50F0F);
      step();
      set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      step();
      step();
      set_port(0, 1'b1, 1'b0, 8'h33, 32'h0);
      step();
      set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      reset_n = 1'b0;
      model_reset();
      step();
      chk("midrst_rsp0", 64'(obs_rsp), 64'h0);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("midrst_rsp%0d", k + 1), 64'(obs_rsp), 64'h0);
      end
      set_port(0, 1'b1, 1'b0, 8'h33, 32'h0);
      step();
      set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      step();
      step();
      chk("postrst_rsp", 64'(obs_rsp), 64'h1);
      chk("postrst_rdata", 64'(obs_data), 64'hA5A50F0F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
